// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-RAM port arbiter.
//   - FSM state encoding (2 bits) and owner encoding
//   - Word byte-enable constant
//   - Width helpers for the wait and streak counters
package mem_arb_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_ISSUE = S_ISSUE,
    ST_WAIT  = S_WAIT,
    ST_RESP  = S_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } arb_owner_t;

  localparam logic [3:0] SEL_WORD = 4'b1111;

  // RAM_LAT is limited to 1..7, so three bits always hold the wait count.
  localparam int LAT_W = 3;

  function automatic int streak_width(input int max_streak);
    return $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Priority decision for the data-RAM arbiter (purely combinational).
// MEM normally wins; IF wins once MEM has taken MAX_MEM_STREAK grants in a
// row while IF was waiting.
// Ports:
//   i_if_req        IF read request
//   i_mem_req       MEM request
//   i_streak        consecutive MEM grants seen while IF was pending
//   o_grant_valid   some requester can be granted
//   o_grant_owner   which requester wins (valid with o_grant_valid)
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int MAX_MEM_STREAK = 4,
  parameter int STREAK_W       = streak_width(MAX_MEM_STREAK)
) (
  input  logic                i_if_req,
  input  logic                i_mem_req,
  input  logic [STREAK_W-1:0] i_streak,
  output logic                o_grant_valid,
  output arb_owner_t          o_grant_owner
);

  logic w_if_starved;

  assign w_if_starved = i_if_req && (i_streak == STREAK_W'(MAX_MEM_STREAK));

  always_comb begin
    o_grant_valid = i_mem_req | i_if_req;
    o_grant_owner = OWN_IF;
    if (i_mem_req && !w_if_starved) begin
      o_grant_owner = OWN_MEM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port data RAM between instruction fetch (IF) and the
// load/store stage (MEM). Each access runs IDLE -> ISSUE -> WAIT -> RESP and
// ends with a one-cycle ack to its owner. All outputs are registered except
// the stall requests.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access in flight; requests are sampled and one granted
// ISSUE | ram_ce strobe with the latched address/sel/wdata
// WAIT  | counting down RAM_LAT; read data captured on the last count
// RESP  | owner's ack is high for this one cycle
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-low reset
//   i_if_req/addr/flush     IF read request, word address, pipeline flush
//   o_if_ack/rdata          IF completion pulse and instruction word
//   i_mem_req/we/addr/sel/wdata   MEM request, store flag, address, byte
//                           enables, store data
//   o_mem_ack/rdata         MEM completion pulse and load data
//   o_ram_*                 RAM strobe, write enable, address, sel, wdata
//   i_ram_rdata             RAM read data
//   o_stallreq_if/mem       requester waiting (to pipeline control)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int RAM_LAT        = 1,
  parameter int MAX_MEM_STREAK = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_flush,
  output logic              o_if_ack,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [3:0]        i_mem_sel,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic              o_mem_ack,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_ram_ce,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [3:0]        o_ram_sel,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_stallreq_if,
  output logic              o_stallreq_mem
);

  localparam int STREAK_W = streak_width(MAX_MEM_STREAK);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  arb_owner_t          r_owner;
  logic                r_is_store;
  logic                r_cancel;
  logic [LAT_W-1:0]    r_wait_cnt;
  logic [STREAK_W-1:0] r_streak;

  logic                r_if_ack;
  logic                r_mem_ack;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_mem_rdata;
  logic                r_ram_ce;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [3:0]          r_ram_sel;
  logic [DATA_W-1:0]   r_ram_wdata;

  logic                w_grant_valid;
  arb_owner_t          w_grant_owner;
  logic                w_last_wait;
  logic                w_if_cancelled;
  logic [STREAK_W-1:0] w_streak_inc;

  mem_arb_grant #(
    .MAX_MEM_STREAK (MAX_MEM_STREAK),
    .STREAK_W       (STREAK_W)
  ) u_grant (
    .i_if_req      (i_if_req),
    .i_mem_req     (i_mem_req),
    .i_streak      (r_streak),
    .o_grant_valid (w_grant_valid),
    .o_grant_owner (w_grant_owner)
  );

  assign w_last_wait = (r_wait_cnt == LAT_W'(1));
  // A flush arriving in the very cycle the data is captured still cancels.
  assign w_if_cancelled = r_cancel | i_if_flush;
  assign w_streak_inc = (r_streak == STREAK_W'(MAX_MEM_STREAK)) ?
                        r_streak : (r_streak + STREAK_W'(1));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_grant_valid) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (w_last_wait) w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_owner     <= OWN_IF;
      r_is_store  <= 1'b0;
      r_cancel    <= 1'b0;
      r_wait_cnt  <= '0;
      r_streak    <= '0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_ram_ce    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_sel   <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_owner  <= w_grant_owner;
            r_ram_ce <= 1'b1;
            if (w_grant_owner == OWN_MEM) begin
              r_is_store  <= i_mem_we;
              r_ram_we    <= i_mem_we;
              r_ram_addr  <= i_mem_addr;
              r_ram_sel   <= i_mem_sel;
              r_ram_wdata <= i_mem_wdata;
              // Only MEM grants that overtake a waiting IF count toward starvation.
              r_streak    <= i_if_req ? w_streak_inc : '0;
            end else begin
              r_is_store  <= 1'b0;
              r_ram_we    <= 1'b0;
              r_ram_addr  <= i_if_addr;
              r_ram_sel   <= SEL_WORD;
              r_ram_wdata <= '0;
              r_streak    <= '0;
            end
          end
        end
        ST_ISSUE: begin
          r_ram_ce   <= 1'b0;
          r_ram_we   <= 1'b0;
          r_wait_cnt <= LAT_W'(RAM_LAT);
          if (r_owner == OWN_IF && i_if_flush) r_cancel <= 1'b1;
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt - LAT_W'(1);
          if (r_owner == OWN_IF && i_if_flush) r_cancel <= 1'b1;
          if (w_last_wait) begin
            if (r_owner == OWN_MEM) begin
              r_mem_ack   <= 1'b1;
              r_mem_rdata <= r_is_store ? '0 : i_ram_rdata;
            end else if (!w_if_cancelled) begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= i_ram_rdata;
            end
          end
        end
        ST_RESP: begin
          r_cancel <= 1'b0;
        end
        default: begin
          r_cancel <= 1'b0;
        end
      endcase
    end
  end

  assign o_if_ack    = r_if_ack;
  assign o_if_rdata  = r_if_rdata;
  assign o_mem_ack   = r_mem_ack;
  assign o_mem_rdata = r_mem_rdata;
  assign o_ram_ce    = r_ram_ce;
  assign o_ram_we    = r_ram_we;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_sel   = r_ram_sel;
  assign o_ram_wdata = r_ram_wdata;

  assign o_stallreq_if  = i_if_req & ~r_if_ack;
  assign o_stallreq_mem = i_mem_req & ~r_mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic        if_ack, mem_ack, ram_ce, ram_we, stall_if, stall_mem;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic [3:0]  ram_sel;
  logic [31:0] ram_rdata_q;

  logic        pre_en;
  logic [3:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] ram [0:15];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic        is_mem;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .RAM_LAT(1), .MAX_MEM_STREAK(4)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
    .o_if_ack(if_ack), .o_if_rdata(if_rdata),
    .i_mem_req(mem_req), .i_mem_we(mem_we), .i_mem_addr(mem_addr),
    .i_mem_sel(mem_sel), .i_mem_wdata(mem_wdata),
    .o_mem_ack(mem_ack), .o_mem_rdata(mem_rdata),
    .o_ram_ce(ram_ce), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_sel(ram_sel), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata_q),
    .o_stallreq_if(stall_if), .o_stallreq_mem(stall_mem)
  );

  // Single-port RAM model, one cycle read latency, word indexed by addr[3:0].
  always @(posedge clk) begin
    if (pre_en) begin
      ram[pre_addr] <= pre_data;
    end else if (ram_ce) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_sel[b]) ram[ram_addr[3:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata_q <= ram[ram_addr[3:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic sb_expect(input logic is_mem, input logic [31:0] data, input int lat);
    exp_t e;
    e.is_mem = is_mem;
    e.data   = data;
    e.due    = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic sb_pop();
    exp_t e;
    check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("ack_owner", {30'd0, mem_ack, if_ack}, e.is_mem ? 32'd2 : 32'd1);
      check("ack_data", e.is_mem ? mem_rdata : if_rdata, e.data);
      check("ack_cycle", 32'(cyc), 32'(e.due));
      if (e.is_mem) check("stall_mem_at_ack", 32'(stall_mem), 32'd0);
      else          check("stall_if_at_ack", 32'(stall_if), 32'd0);
    end
  endtask

  task automatic wait_ack(input int budget);
    bit got = 1'b0;
    for (int n = 0; n < budget && !got; n++) begin
      tick();
      if (if_ack || mem_ack) begin
        got = 1'b1;
        sb_pop();
      end else begin
        check("stall_if_waiting", 32'(stall_if), 32'(if_req));
        check("stall_mem_waiting", 32'(stall_mem), 32'(mem_req));
      end
    end
    check("ack_within_budget", 32'(got), 32'd1);
  endtask

  task automatic mem_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata);
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_sel = sel; mem_wdata = wdata;
    sb_expect(1'b1, we ? 32'd0 : exp_rdata, 3);
    tick();
    check("issue_ram_ce", 32'(ram_ce), 32'd1);
    check("issue_ram_we", 32'(ram_we), 32'(we));
    check("issue_ram_addr", ram_addr, addr);
    check("issue_ram_sel", 32'(ram_sel), 32'(sel));
    if (we) check("issue_ram_wdata", ram_wdata, wdata);
    wait_ack(12);
    mem_req = 1'b0; mem_we = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_sel = '0; mem_wdata = '0;
    pre_en = 1'b1; pre_addr = 4'd0; pre_data = 32'h3401_1234;
    tick();
    pre_addr = 4'd1; pre_data = 32'h5555_AAAA;
    tick();
    pre_addr = 4'd2; pre_data = 32'h0000_0000;
    tick();
    pre_en = 1'b0;

    // Reset state
    check("rst_if_ack", 32'(if_ack), 32'd0);
    check("rst_mem_ack", 32'(mem_ack), 32'd0);
    check("rst_ram_ce", 32'(ram_ce), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_sel", 32'(ram_sel), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    rst = 1'b1;
    tick();

    // Single IF read
    if_req = 1'b1; if_addr = 32'd0;
    sb_expect(1'b0, 32'h3401_1234, 3);
    #1;
    check("if_stall_c0", 32'(stall_if), 32'd1);
    tick();
    check("if_issue_ce", 32'(ram_ce), 32'd1);
    check("if_issue_we", 32'(ram_we), 32'd0);
    check("if_issue_sel", 32'(ram_sel), 32'hF);
    check("if_issue_addr", ram_addr, 32'd0);
    check("if_stall_c1", 32'(stall_if), 32'd1);
    tick();
    check("if_wait_ce", 32'(ram_ce), 32'd0);
    check("if_stall_c2", 32'(stall_if), 32'd1);
    wait_ack(12);
    if_req = 1'b0;
    tick();

    // Store then loads, including a partial-byte store
    mem_access(1'b1, 32'd0, 4'b1111, 32'h0000_89AB, 32'd0);
    mem_access(1'b0, 32'd0, 4'b1111, 32'd0, 32'h0000_89AB);
    mem_access(1'b1, 32'd2, 4'b0101, 32'hAABB_CCDD, 32'd0);
    mem_access(1'b0, 32'd2, 4'b1111, 32'd0, 32'h00BB_00DD);

    // Simultaneous requests: MEM first, IF at the next IDLE
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'd0; mem_sel = 4'hF;
    if_req = 1'b1; if_addr = 32'd0;
    sb_expect(1'b1, 32'h0000_89AB, 3);
    sb_expect(1'b0, 32'h0000_89AB, 7);
    wait_ack(12);
    check("sim_if_stalled_at_mem_ack", 32'(stall_if), 32'd1);
    mem_req = 1'b0;
    wait_ack(12);
    if_req = 1'b0;
    tick();

    // Starvation guard: four MEM grants, then IF, then streak restarts
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'd2; mem_sel = 4'hF;
    if_req = 1'b1; if_addr = 32'd0;
    for (int k = 0; k < 4; k++) sb_expect(1'b1, 32'h00BB_00DD, 3 + 4*k);
    sb_expect(1'b0, 32'h0000_89AB, 19);
    for (int k = 0; k < 5; k++) wait_ack(12);
    if_req = 1'b0;
    sb_expect(1'b1, 32'h00BB_00DD, 4);
    tick();
    if_req = 1'b1;
    sb_expect(1'b0, 32'h0000_89AB, 7);
    wait_ack(12);
    mem_req = 1'b0;
    wait_ack(12);
    if_req = 1'b0;
    tick();

    // Flush during WAIT cancels the IF ack; FSM idle again at +4
    if_req = 1'b1; if_addr = 32'd1;
    tick();
    check("flush_issue_ce", 32'(ram_ce), 32'd1);
    tick();
    check("flush_c2_no_ack", 32'(if_ack), 32'd0);
    if_flush = 1'b1; if_req = 1'b0;
    tick();
    check("flush_c3_no_ack", 32'(if_ack), 32'd0);
    check("flush_rdata_kept", if_rdata, 32'h0000_89AB);
    if_flush = 1'b0;
    tick();
    check("flush_c4_no_ack", 32'(if_ack), 32'd0);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'd1; mem_sel = 4'hF;
    sb_expect(1'b1, 32'h5555_AAAA, 3);
    wait_ack(12);
    mem_req = 1'b0;
    tick();

    // Reset during WAIT of a load, then reissue
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'd2; mem_sel = 4'hF;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("mid_rst_mem_ack", 32'(mem_ack), 32'd0);
    check("mid_rst_ram_ce", 32'(ram_ce), 32'd0);
    check("mid_rst_ram_addr", ram_addr, 32'd0);
    check("mid_rst_ram_sel", 32'(ram_sel), 32'd0);
    check("mid_rst_mem_rdata", mem_rdata, 32'd0);
    check("mid_rst_if_rdata", if_rdata, 32'd0);
    rst = 1'b1;
    sb_expect(1'b1, 32'h00BB_00DD, 3);
    wait_ack(12);
    mem_req = 1'b0;
    tick();
    tick();
    check("no_stray_ack", 32'(if_ack | mem_ack), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
